// File: rtl/food_sprite_pkg.sv
// Shared types, sprite ROM and colour helpers for the food sprite renderer.
package food_sprite_pkg;

    typedef enum logic [1:0] {
        FOOD_NONE   = 2'd0,
        FOOD_SMALL  = 2'd1,
        FOOD_MEDIUM = 2'd2,
        FOOD_POWER  = 2'd3
    } food_type_t;

    localparam int SPRITE_EDGE = 4;

    // Indexed [type][row]; row 0 is the top row, pixel column 0 sits in bits [7:6].
    localparam logic [7:0] FOOD_ROM [4][4] = '{
        '{8'b00000000, 8'b00000000, 8'b00000000, 8'b00000000},
        '{8'b00000000, 8'b00101000, 8'b00101000, 8'b00000000},
        '{8'b00101000, 8'b10010110, 8'b10010110, 8'b00101000},
        '{8'b10101010, 8'b10111110, 8'b10111110, 8'b10101010}
    };

    function automatic logic [1:0] sprite_pixel(food_type_t kind, logic [1:0] row,
                                                logic [1:0] col);
        logic [7:0] bits;
        bits = FOOD_ROM[kind][row];
        return 2'(bits >> (3'd6 - {col, 1'b0}));
    endfunction

    function automatic logic [1:0] colour_swap(logic [1:0] colour, logic odd);
        if (odd && (colour == 2'd1 || colour == 2'd2)) begin
            return ~colour;
        end
        return colour;
    endfunction

endpackage

// File: rtl/food_sprite_renderer_if.sv
// Pixel request / colour response bundle between the cell fetch and the food renderer.
interface food_sprite_renderer_if
    import food_sprite_pkg::*;
#(
    parameter int CELL_BITS = 4
);
    logic                 pix_valid;
    logic [CELL_BITS-1:0] x;
    logic [CELL_BITS-1:0] y;
    food_type_t           food_type;
    logic [1:0]           value;
    logic                 value_valid;

    modport master (
        output pix_valid, x, y, food_type,
        input  value, value_valid
    );

    modport slave (
        input  pix_valid, x, y, food_type,
        output value, value_valid
    );
endinterface

// File: rtl/food_anim_timer.sv
// Frame-tick driven animation frame counter; adds the blink phase when FOOD_BLINK_EN is defined.
module food_anim_timer #(
    parameter int FRAMES    = 2,
    parameter int FRAME_DIV = 15,
`ifdef FOOD_BLINK_EN
    parameter int BLINK_DIV = 30,
`endif
    localparam int FW = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_tick,
`ifdef FOOD_BLINK_EN
    output logic          blink_phase,
`endif
    output logic [FW-1:0] anim_frame
);
    localparam int TW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    logic [TW-1:0] tick_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt   <= '0;
            anim_frame <= '0;
        end else if (frame_tick) begin
            if (tick_cnt == TW'(FRAME_DIV - 1)) begin
                tick_cnt   <= '0;
                anim_frame <= (anim_frame == FW'(FRAMES - 1)) ? '0 : anim_frame + 1'b1;
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
            end
        end
    end

`ifdef FOOD_BLINK_EN
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BW-1:0] blink_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_tick) begin
            if (blink_cnt == BW'(BLINK_DIV - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/food_sprite_renderer.sv
// Two-stage food sprite pixel renderer with frame-swap animation (optional FOOD_BLINK_EN power-pellet blink).
module food_sprite_renderer
    import food_sprite_pkg::*;
#(
    parameter int CELL_BITS = 4,
    parameter int SCALE     = 0,
    parameter int FRAMES    = 2,
    parameter int FRAME_DIV = 15,
    parameter int BLINK_DIV = 30,
    localparam int FW = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_tick,
    food_sprite_renderer_if.slave  pix,
    output logic [FW-1:0]          anim_frame
);
    localparam int FOOT = SPRITE_EDGE << SCALE;
    localparam int ORG  = ((1 << CELL_BITS) - FOOT) / 2;
    localparam logic [CELL_BITS-1:0] LO = CELL_BITS'(ORG);
    localparam logic [CELL_BITS-1:0] HI = CELL_BITS'(ORG + FOOT - 1);

    if (FOOT > (1 << CELL_BITS) || FRAME_DIV < 1 || BLINK_DIV < 1 ||
        !(FRAMES == 1 || FRAMES == 2 || FRAMES == 4)) begin : g_bad_params
        $error("food_sprite_renderer: illegal parameter set");
    end

`ifdef FOOD_BLINK_EN
    logic blink_phase;
`endif

    food_anim_timer #(
        .FRAMES    (FRAMES),
`ifdef FOOD_BLINK_EN
        .BLINK_DIV (BLINK_DIV),
`endif
        .FRAME_DIV (FRAME_DIV)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
`ifdef FOOD_BLINK_EN
        .blink_phase(blink_phase),
`endif
        .anim_frame (anim_frame)
    );

    // Stage 1: box test, sprite coordinates, frame/phase capture
    logic       vld_p1;
    logic       in_box_p1;
    logic [1:0] col_p1;
    logic [1:0] row_p1;
    food_type_t type_p1;
    logic       odd_p1;
`ifdef FOOD_BLINK_EN
    logic       blink_p1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= pix.pix_valid;
        end
    end

    always_ff @(posedge clk) begin
        in_box_p1 <= (pix.x >= LO) && (pix.x <= HI) && (pix.y >= LO) && (pix.y <= HI);
        col_p1    <= 2'((pix.x - LO) >> SCALE);
        row_p1    <= 2'((pix.y - LO) >> SCALE);
        type_p1   <= pix.food_type;
        // With FRAMES=1 the frame counter never leaves 0, so no swap is ever requested.
        odd_p1    <= anim_frame[0];
`ifdef FOOD_BLINK_EN
        blink_p1  <= blink_phase;
`endif
    end

    // Stage 2: ROM lookup, colour transform, registered output
    logic [1:0] shade;
    logic [1:0] value_p2;
    logic       vld_p2;

    always_comb begin
        shade = 2'd0;
        if (in_box_p1) begin
            shade = colour_swap(sprite_pixel(type_p1, row_p1, col_p1), odd_p1);
        end
`ifdef FOOD_BLINK_EN
        if (blink_p1 && type_p1 == FOOD_POWER) begin
            shade = 2'd0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_p2 <= 2'd0;
            vld_p2   <= 1'b0;
        end else begin
            value_p2 <= shade;
            vld_p2   <= vld_p1;
        end
    end

    assign pix.value       = value_p2;
    assign pix.value_valid = vld_p2;

endmodule

// File: tb/tb_food_sprite_renderer.sv
// Directed-vector bench for food_sprite_renderer: default cell plus a 32-pixel, 2x-scaled instance.
module tb_food_sprite_renderer;
    import food_sprite_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic frame_tick = 1'b0;
    logic [0:0] anim0;
    logic [0:0] anim1;

    always #5 clk = ~clk;

    food_sprite_renderer_if #(.CELL_BITS(4)) bus0 ();
    food_sprite_renderer_if #(.CELL_BITS(5)) bus1 ();

    food_sprite_renderer #(.BLINK_DIV(2)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .pix        (bus0.slave),
        .anim_frame (anim0)
    );

    food_sprite_renderer #(.CELL_BITS(5), .SCALE(1)) u_big (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .pix        (bus1.slave),
        .anim_frame (anim1)
    );

    typedef struct {
        int x;
        int y;
        int t;
        int e;
    } vec_t;

    vec_t q[$];
    int vectors = 0;
    int miscompares = 0;
    int nz;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        frame_tick = 1'b1;
        repeat (n) step();
        frame_tick = 1'b0;
    endtask

    task automatic probe0(input string tag, input int x, input int y, input int t, input int e);
        bus0.pix_valid = 1'b1;
        bus0.x = 4'(x);
        bus0.y = 4'(y);
        bus0.food_type = food_type_t'(t);
        step();
        bus0.pix_valid = 1'b0;
        step();
        chk({tag, "_vld"}, 32'(bus0.value_valid), 1);
        chk(tag, 32'(bus0.value), 32'(e));
    endtask

    task automatic probe1(input string tag, input int x, input int y, input int t, input int e);
        bus1.pix_valid = 1'b1;
        bus1.x = 5'(x);
        bus1.y = 5'(y);
        bus1.food_type = food_type_t'(t);
        step();
        bus1.pix_valid = 1'b0;
        step();
        chk({tag, "_vld"}, 32'(bus1.value_valid), 1);
        chk(tag, 32'(bus1.value), 32'(e));
    endtask

    // Back-to-back stream on the default instance; each result is due one step after the next drive.
    task automatic run_stream(input string tag, output int nonzero);
        nonzero = 0;
        for (int i = 0; i <= q.size(); i++) begin
            if (i < q.size()) begin
                bus0.pix_valid = 1'b1;
                bus0.x = 4'(q[i].x);
                bus0.y = 4'(q[i].y);
                bus0.food_type = food_type_t'(q[i].t);
            end else begin
                bus0.pix_valid = 1'b0;
            end
            step();
            if (i >= 1) begin
                chk($sformatf("%s_vld%0d", tag, i - 1), 32'(bus0.value_valid), 1);
                chk($sformatf("%s_val%0d", tag, i - 1), 32'(bus0.value), 32'(q[i - 1].e));
                if (bus0.value != 2'd0) nonzero++;
            end
        end
        step();
        chk({tag, "_idle_vld"}, 32'(bus0.value_valid), 0);
        q.delete();
    endtask

    initial begin
        bus0.pix_valid = 1'b0;
        bus0.x = '0;
        bus0.y = '0;
        bus0.food_type = FOOD_NONE;
        bus1.pix_valid = 1'b0;
        bus1.x = '0;
        bus1.y = '0;
        bus1.food_type = FOOD_NONE;

        step();
        step();
        chk("rst_value", 32'(bus0.value), 0);
        chk("rst_vld", 32'(bus0.value_valid), 0);
        chk("rst_anim", 32'(anim0), 0);
        chk("rst_big_vld", 32'(bus1.value_valid), 0);
        rst = 1'b0;
        step();

        // 32-pixel cell, 2x sprite: box is 12..19
        probe1("big_14_14_med", 14, 14, 2, 1);
        probe1("big_12_12_pow", 12, 12, 3, 2);
        probe1("big_11_12_pow", 11, 12, 3, 0);
        probe1("big_20_12_pow", 20, 12, 3, 0);
        probe1("big_19_19_pow", 19, 19, 3, 2);

        q.push_back('{x: 6, y: 7, t: 2, e: 2});
        q.push_back('{x: 5, y: 7, t: 2, e: 0});
        q.push_back('{x: 9, y: 9, t: 3, e: 2});
        q.push_back('{x: 10, y: 9, t: 3, e: 0});
        q.push_back('{x: 6, y: 6, t: 0, e: 0});
        run_stream("burst", nz);

        for (int yy = 0; yy < 16; yy++) begin
            for (int xx = 0; xx < 16; xx++) begin
                q.push_back('{x: xx, y: yy, t: 1,
                              e: ((xx == 7 || xx == 8) && (yy == 7 || yy == 8)) ? 2 : 0});
            end
        end
        run_stream("cell", nz);
        chk("cell_nonzero", 32'(nz), 4);

        ticks(14);
        chk("anim_after14", 32'(anim0), 0);
        ticks(1);
        chk("anim_after15", 32'(anim0), 1);
        probe0("f1_med_swap", 6, 7, 2, 1);
        probe0("f1_pow_noswap", 7, 7, 3, 3);
        probe0("f1_small_swap", 7, 7, 1, 1);
        probe0("f1_out", 5, 7, 3, 0);
        ticks(15);
        chk("anim_wrap", 32'(anim0), 0);
        probe0("f0_med", 6, 7, 2, 2);

        ticks(10);
        bus0.pix_valid = 1'b1;
        bus0.x = 4'(6);
        bus0.y = 4'(7);
        bus0.food_type = FOOD_MEDIUM;
        step();
        rst = 1'b1;
        step();
        chk("midrst_vld", 32'(bus0.value_valid), 0);
        chk("midrst_value", 32'(bus0.value), 0);
        chk("midrst_anim", 32'(anim0), 0);
        rst = 1'b0;
        bus0.pix_valid = 1'b0;
        step();
        chk("midrst_vld_next", 32'(bus0.value_valid), 0);
        step();
        chk("midrst_vld_drain", 32'(bus0.value_valid), 0);
        ticks(14);
        chk("midrst_anim14", 32'(anim0), 0);
        ticks(1);
        chk("midrst_anim15", 32'(anim0), 1);

        rst = 1'b1;
        step();
        rst = 1'b0;
        probe0("blk_pow_t0", 7, 7, 3, 3);
        probe0("blk_med_t0", 6, 7, 2, 2);
        ticks(2);
`ifdef FOOD_BLINK_EN
        probe0("blk_pow_t2", 7, 7, 3, 0);
`else
        probe0("blk_pow_t2", 7, 7, 3, 3);
`endif
        probe0("blk_med_t2", 6, 7, 2, 2);
        ticks(2);
        probe0("blk_pow_t4", 7, 7, 3, 3);
        probe0("blk_med_t4", 6, 7, 2, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
